// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline stall/flush controller.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    localparam int STATE_W    = 2;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Brief    : Hazard inputs, refill handshake and stage controls of the pipeline.
// Revision : 1.0
// ============================================================================
interface pipeline_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] IF_ID_RS1addr_i;
    logic [REG_ADDR_W-1:0] IF_ID_RS2addr_i;
    logic                  IF_ID_useRS2_i;
    logic                  ID_EX_MemRead_i;
    logic [REG_ADDR_W-1:0] ID_EX_RDaddr_i;
    logic                  branch_taken_i;
    logic                  dmem_req_i;
    logic                  dmem_hit_i;
    logic                  mem_ack_i;
    logic                  mem_req_o;
    logic                  PC_write_o;
    logic                  IF_ID_stall_o;
    logic                  IF_ID_flush_o;
    logic                  ID_EX_stall_o;
    logic                  ID_EX_bubble_o;
    logic                  EX_MEM_stall_o;
    logic                  MEM_WB_stall_o;

    // Pipeline datapath side.
    modport master (
        output IF_ID_RS1addr_i, IF_ID_RS2addr_i, IF_ID_useRS2_i,
        output ID_EX_MemRead_i, ID_EX_RDaddr_i, branch_taken_i,
        output dmem_req_i, dmem_hit_i, mem_ack_i,
        input  mem_req_o, PC_write_o, IF_ID_stall_o, IF_ID_flush_o,
        input  ID_EX_stall_o, ID_EX_bubble_o, EX_MEM_stall_o, MEM_WB_stall_o
    );

    // Controller side.
    modport slave (
        input  IF_ID_RS1addr_i, IF_ID_RS2addr_i, IF_ID_useRS2_i,
        input  ID_EX_MemRead_i, ID_EX_RDaddr_i, branch_taken_i,
        input  dmem_req_i, dmem_hit_i, mem_ack_i,
        output mem_req_o, PC_write_o, IF_ID_stall_o, IF_ID_flush_o,
        output ID_EX_stall_o, ID_EX_bubble_o, EX_MEM_stall_o, MEM_WB_stall_o
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use compare between EX load and ID sources.
// Revision : 1.0
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  use_rs2,
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = mem_read && (rd != REG_X0) &&
                      ((rd == rs1) || (use_rs2 && (rd == rs2)));

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush controller with data-cache miss freeze and refill FSM.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int MISS_CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_ctrl_if.slave        bus,
    output logic [31:0]           stall_cnt_o,
    output logic [MISS_CNT_W-1:0] miss_cnt_o,
    output logic                  err_o,
    output logic [STATE_W-1:0]    state_o
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(ACK_TIMEOUT);

    state_t     state;
    state_t     next_state;
    logic       load_use;
    logic       miss_start;
    logic       pc_write;
    logic       mem_req;
    logic [7:0] wait_cnt;

    hazard_detect u_hazard (
        .rs1      (bus.IF_ID_RS1addr_i),
        .rs2      (bus.IF_ID_RS2addr_i),
        .use_rs2  (bus.IF_ID_useRS2_i),
        .mem_read (bus.ID_EX_MemRead_i),
        .rd       (bus.ID_EX_RDaddr_i),
        .load_use (load_use)
    );

    always_comb begin
        next_state         = ST_RUN;
        miss_start         = 1'b0;
        pc_write           = 1'b1;
        bus.IF_ID_stall_o  = 1'b0;
        bus.IF_ID_flush_o  = 1'b0;
        bus.ID_EX_stall_o  = 1'b0;
        bus.ID_EX_bubble_o = 1'b0;
        bus.EX_MEM_stall_o = 1'b0;
        bus.MEM_WB_stall_o = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.dmem_req_i && !bus.dmem_hit_i) begin
                    next_state = ST_MISS;
                    miss_start = 1'b1;
                end else if (load_use) begin
                    // Branch waits: it re-resolves once the load result is forwarded.
                    pc_write           = 1'b0;
                    bus.IF_ID_stall_o  = 1'b1;
                    bus.ID_EX_bubble_o = 1'b1;
                end else if (bus.branch_taken_i) begin
                    bus.IF_ID_flush_o = 1'b1;
                end
            end
            ST_MISS:   next_state = bus.mem_ack_i ? ST_REFILL : ST_MISS;
            ST_REFILL: next_state = ST_RUN;
            default:   next_state = ST_RUN;
        endcase
        if (miss_start || state == ST_MISS || state == ST_REFILL) begin
            pc_write           = 1'b0;
            bus.IF_ID_stall_o  = 1'b1;
            bus.ID_EX_stall_o  = 1'b1;
            bus.EX_MEM_stall_o = 1'b1;
            bus.MEM_WB_stall_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_RUN;
            mem_req     <= 1'b0;
            stall_cnt_o <= '0;
            miss_cnt_o  <= '0;
            err_o       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state   <= next_state;
            mem_req <= (next_state == ST_MISS);
            if (!pc_write && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (miss_start && miss_cnt_o != '1)
                miss_cnt_o <= miss_cnt_o + MISS_CNT_W'(1);
            // An ack arriving on the timeout cycle takes precedence over the error.
            if (state == ST_MISS) begin
                if (!bus.mem_ack_i) begin
                    if (wait_cnt != TIMEOUT_VAL)
                        wait_cnt <= wait_cnt + 8'd1;
                    if (wait_cnt + 8'd1 == TIMEOUT_VAL)
                        err_o <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign bus.mem_req_o  = mem_req;
    assign bus.PC_write_o = pc_write;
    assign state_o        = state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed self-checking bench for pipeline_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipeline_ctrl;

    // Control vector order: PC_write, IF_ID_stall, IF_ID_flush, ID_EX_stall,
    // ID_EX_bubble, EX_MEM_stall, MEM_WB_stall.
    localparam logic [6:0] C_IDLE   = 7'b1000000;
    localparam logic [6:0] C_LU     = 7'b0100100;
    localparam logic [6:0] C_BR     = 7'b1010000;
    localparam logic [6:0] C_FREEZE = 7'b0101011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [31:0] stall_a, stall_b;
    logic [15:0] miss_a;
    logic [3:0]  miss_b;
    logic        err_a, err_b;
    logic [1:0]  st_a, st_b;
    logic [6:0]  ctrl_a, ctrl_b;
    int          n_vec = 0;
    int          n_bad = 0;

    pipeline_ctrl_if bus_a ();
    pipeline_ctrl_if bus_b ();

    pipeline_ctrl #(.ACK_TIMEOUT(255), .MISS_CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .bus(bus_a),
        .stall_cnt_o(stall_a), .miss_cnt_o(miss_a), .err_o(err_a), .state_o(st_a)
    );

    pipeline_ctrl #(.ACK_TIMEOUT(3), .MISS_CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .bus(bus_b),
        .stall_cnt_o(stall_b), .miss_cnt_o(miss_b), .err_o(err_b), .state_o(st_b)
    );

    assign ctrl_a = {bus_a.PC_write_o, bus_a.IF_ID_stall_o, bus_a.IF_ID_flush_o, bus_a.ID_EX_stall_o,
                     bus_a.ID_EX_bubble_o, bus_a.EX_MEM_stall_o, bus_a.MEM_WB_stall_o};
    assign ctrl_b = {bus_b.PC_write_o, bus_b.IF_ID_stall_o, bus_b.IF_ID_flush_o, bus_b.ID_EX_stall_o,
                     bus_b.ID_EX_bubble_o, bus_b.EX_MEM_stall_o, bus_b.MEM_WB_stall_o};

    task automatic idle_a;
        bus_a.IF_ID_RS1addr_i = '0; bus_a.IF_ID_RS2addr_i = '0; bus_a.IF_ID_useRS2_i = 1'b0;
        bus_a.ID_EX_MemRead_i = 1'b0; bus_a.ID_EX_RDaddr_i = '0; bus_a.branch_taken_i = 1'b0;
        bus_a.dmem_req_i = 1'b0; bus_a.dmem_hit_i = 1'b0; bus_a.mem_ack_i = 1'b0;
    endtask

    task automatic idle_b;
        bus_b.IF_ID_RS1addr_i = '0; bus_b.IF_ID_RS2addr_i = '0; bus_b.IF_ID_useRS2_i = 1'b0;
        bus_b.ID_EX_MemRead_i = 1'b0; bus_b.ID_EX_RDaddr_i = '0; bus_b.branch_taken_i = 1'b0;
        bus_b.dmem_req_i = 1'b0; bus_b.dmem_hit_i = 1'b0; bus_b.mem_ack_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_a = 1'b0; rst_b = 1'b0;
        idle_a(); idle_b();
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (st_a !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d exp 0", st_a); end
        n_vec++; if (bus_a.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b exp 0", bus_a.mem_req_o); end
        n_vec++; if (stall_a !== 32'd0 || miss_a !== 16'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", stall_a, miss_a); end
        n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", err_a); end
        n_vec++; if (ctrl_a !== C_IDLE) begin n_bad++; $display("FAIL reset_ctrl: got %b exp %b", ctrl_a, C_IDLE); end
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
    endtask

    task automatic test_load_use;
        @(negedge clk);
        bus_a.ID_EX_MemRead_i = 1'b1; bus_a.ID_EX_RDaddr_i = 5'd5; bus_a.IF_ID_RS1addr_i = 5'd5;
        #1;
        n_vec++; if (ctrl_a !== C_LU) begin n_bad++; $display("FAIL load_use_ctrl: got %b exp %b", ctrl_a, C_LU); end
        @(negedge clk);
        idle_a();
        #1;
        n_vec++; if (ctrl_a !== C_IDLE) begin n_bad++; $display("FAIL load_use_release: got %b exp %b", ctrl_a, C_IDLE); end
        n_vec++; if (stall_a !== 32'd1) begin n_bad++; $display("FAIL load_use_stall_cnt: got %0d exp 1", stall_a); end
    endtask

    task automatic test_x0_rs2;
        @(negedge clk);
        bus_a.ID_EX_MemRead_i = 1'b1; bus_a.ID_EX_RDaddr_i = 5'd0; bus_a.IF_ID_RS1addr_i = 5'd0;
        #1;
        n_vec++; if (ctrl_a !== C_IDLE) begin n_bad++; $display("FAIL x0_no_stall: got %b exp %b", ctrl_a, C_IDLE); end
        @(negedge clk);
        bus_a.ID_EX_RDaddr_i = 5'd7; bus_a.IF_ID_RS1addr_i = 5'd3; bus_a.IF_ID_RS2addr_i = 5'd7;
        bus_a.IF_ID_useRS2_i = 1'b0;
        #1;
        n_vec++; if (ctrl_a !== C_IDLE) begin n_bad++; $display("FAIL rs2_unused: got %b exp %b", ctrl_a, C_IDLE); end
        @(negedge clk);
        bus_a.IF_ID_useRS2_i = 1'b1;
        #1;
        n_vec++; if (ctrl_a !== C_LU) begin n_bad++; $display("FAIL rs2_used: got %b exp %b", ctrl_a, C_LU); end
        @(negedge clk);
        idle_a();
        #1;
        n_vec++; if (stall_a !== 32'd2) begin n_bad++; $display("FAIL rs2_stall_cnt: got %0d exp 2", stall_a); end
    endtask

    task automatic test_branch_priority;
        @(negedge clk);
        bus_a.ID_EX_MemRead_i = 1'b1; bus_a.ID_EX_RDaddr_i = 5'd5; bus_a.IF_ID_RS1addr_i = 5'd5;
        bus_a.branch_taken_i = 1'b1;
        #1;
        n_vec++; if (ctrl_a !== C_LU) begin n_bad++; $display("FAIL branch_vs_load_use: got %b exp %b", ctrl_a, C_LU); end
        @(negedge clk);
        bus_a.ID_EX_MemRead_i = 1'b0;
        #1;
        n_vec++; if (ctrl_a !== C_BR) begin n_bad++; $display("FAIL branch_flush: got %b exp %b", ctrl_a, C_BR); end
        @(negedge clk);
        idle_a();
        #1;
        n_vec++; if (stall_a !== 32'd3) begin n_bad++; $display("FAIL branch_stall_cnt: got %0d exp 3", stall_a); end
    endtask

    task automatic test_miss;
        logic [1:0] st_exp  [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
        logic       req_exp [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [6:0] c_exp;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            // Miss stays visible through REFILL; the controller must not re-trigger.
            bus_a.dmem_req_i = (i < 6);
            bus_a.dmem_hit_i = 1'b0;
            bus_a.mem_ack_i  = (i == 4);
            #1;
            c_exp = (i < 6) ? C_FREEZE : C_IDLE;
            n_vec++; if (st_a !== st_exp[i]) begin n_bad++; $display("FAIL miss_state[%0d]: got %0d exp %0d", i, st_a, st_exp[i]); end
            n_vec++; if (bus_a.mem_req_o !== req_exp[i]) begin n_bad++; $display("FAIL miss_mem_req[%0d]: got %b exp %b", i, bus_a.mem_req_o, req_exp[i]); end
            n_vec++; if (ctrl_a !== c_exp) begin n_bad++; $display("FAIL miss_ctrl[%0d]: got %b exp %b", i, ctrl_a, c_exp); end
        end
        n_vec++; if (miss_a !== 16'd1) begin n_bad++; $display("FAIL miss_cnt: got %0d exp 1", miss_a); end
        n_vec++; if (stall_a !== 32'd9) begin n_bad++; $display("FAIL miss_stall_cnt: got %0d exp 9", stall_a); end
        @(negedge clk);
        idle_a();
    endtask

    task automatic test_reset_mid_miss;
        @(negedge clk);
        bus_a.dmem_req_i = 1'b1; bus_a.dmem_hit_i = 1'b0;
        repeat (2) @(negedge clk);
        idle_a();
        #1;
        n_vec++; if (st_a !== 2'd1 || bus_a.mem_req_o !== 1'b1) begin n_bad++; $display("FAIL pre_reset_miss: got st %0d req %b exp 1 1", st_a, bus_a.mem_req_o); end
        #2 rst_a = 1'b0;
        #1;
        n_vec++; if (st_a !== 2'd0 || bus_a.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL mid_miss_reset: got st %0d req %b exp 0 0", st_a, bus_a.mem_req_o); end
        n_vec++; if (stall_a !== 32'd0 || miss_a !== 16'd0) begin n_bad++; $display("FAIL mid_miss_reset_cnt: got %0d/%0d exp 0/0", stall_a, miss_a); end
        @(negedge clk);
        rst_a = 1'b1; bus_a.mem_ack_i = 1'b1;
        @(negedge clk);
        bus_a.mem_ack_i = 1'b0;
        #1;
        n_vec++; if (st_a !== 2'd0 || bus_a.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL late_ack: got st %0d req %b exp 0 0", st_a, bus_a.mem_req_o); end
        n_vec++; if (ctrl_a !== C_IDLE) begin n_bad++; $display("FAIL late_ack_ctrl: got %b exp %b", ctrl_a, C_IDLE); end
    endtask

    task automatic test_ack_wins;
        @(negedge clk);
        bus_b.dmem_req_i = 1'b1; bus_b.dmem_hit_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus_b.dmem_req_i = 1'b0;
            bus_b.mem_ack_i  = (k == 3);
        end
        @(negedge clk);
        bus_b.mem_ack_i = 1'b0;
        #1;
        n_vec++; if (st_b !== 2'd2) begin n_bad++; $display("FAIL ack_wins_state: got %0d exp 2", st_b); end
        n_vec++; if (err_b !== 1'b0) begin n_bad++; $display("FAIL ack_wins_err: got %b exp 0", err_b); end
        @(negedge clk);
        #1;
        n_vec++; if (st_b !== 2'd0) begin n_bad++; $display("FAIL ack_wins_run: got %0d exp 0", st_b); end
    endtask

    task automatic test_timeout;
        logic       e_exp;
        logic [1:0] s_exp;
        @(negedge clk);
        bus_b.dmem_req_i = 1'b1; bus_b.dmem_hit_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus_b.dmem_req_i = 1'b0;
            bus_b.mem_ack_i  = (k == 5);
            #1;
            e_exp = (k >= 4);
            s_exp = (k <= 5) ? 2'd1 : 2'd2;
            n_vec++; if (err_b !== e_exp) begin n_bad++; $display("FAIL timeout_err[%0d]: got %b exp %b", k, err_b, e_exp); end
            n_vec++; if (st_b !== s_exp) begin n_bad++; $display("FAIL timeout_state[%0d]: got %0d exp %0d", k, st_b, s_exp); end
            n_vec++; if (ctrl_b !== C_FREEZE) begin n_bad++; $display("FAIL timeout_freeze[%0d]: got %b exp %b", k, ctrl_b, C_FREEZE); end
        end
        @(negedge clk);
        bus_b.mem_ack_i = 1'b0;
        #1;
        n_vec++; if (st_b !== 2'd0 || err_b !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got st %0d err %b exp 0 1", st_b, err_b); end
    endtask

    task automatic test_saturation;
        logic [3:0] m_exp;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_vec++; if (miss_b !== 4'd0 || err_b !== 1'b0) begin n_bad++; $display("FAIL sat_reset: got cnt %0d err %b exp 0 0", miss_b, err_b); end
        @(negedge clk);
        rst_b = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus_b.dmem_req_i = 1'b1; bus_b.dmem_hit_i = 1'b0;
            @(negedge clk);
            bus_b.dmem_req_i = 1'b0; bus_b.mem_ack_i = 1'b1;
            @(negedge clk);
            bus_b.mem_ack_i = 1'b0;
            @(negedge clk);
            #1;
            m_exp = (n > 15) ? 4'hF : 4'(n);
            n_vec++; if (miss_b !== m_exp) begin n_bad++; $display("FAIL miss_sat[%0d]: got %0d exp %0d", n, miss_b, m_exp); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_rs2();
        test_branch_priority();
        test_miss();
        test_reset_mid_miss();
        test_ack_wins();
        test_timeout();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
